// File: rtl/shift_ring_ctrl.sv
// Sequencer that uses an external DEPTH-stage serial shift register as a recirculating,
// bit-serial word memory: rotate to the requested word, then read, write or clear it.
module shift_ring_ctrl #(
   parameter int DEPTH = 1024,
   parameter int W     = 8,
   parameter int AW    = $clog2(DEPTH / W),
   parameter int PW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [AW-1:0] cmd_addr,
   input  logic [W-1:0]  cmd_wdata,
   output logic          rsp_valid,
   output logic [W-1:0]  rsp_rdata,
   output logic          rsp_err,
   output logic          busy,
   output logic [PW-1:0] phase,
   output logic          sr_shift,
   output logic          sr_din,
   input  logic          sr_dout
);

   localparam int NW = DEPTH / W;
   localparam int CW = PW + 1;
   localparam int IW = (W > 1) ? $clog2(W) : 1;

   localparam logic [1:0]    OP_READ  = 2'b00;
   localparam logic [1:0]    OP_WRITE = 2'b01;
   localparam logic [1:0]    OP_CLEAR = 2'b10;
   localparam logic [1:0]    OP_RSVD  = 2'b11;
   localparam logic [CW-1:0] CNT_WORD = CW'(W);
   localparam logic [CW-1:0] CNT_RING = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [PW-1:0] PH_ONE   = PW'(1);
   localparam logic [PW-1:0] PH_ZERO  = PW'(0);
   localparam logic [AW:0]   NW_LIMIT = (AW + 1)'(NW);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_SEEK = 2'b01,
      ST_XFER = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   state_t        state_r, state_s;
   logic [PW-1:0] phase_r;
   logic [PW-1:0] target_r, target_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic [1:0]    op_r, op_s;
   logic [W-1:0]  wdata_r, wdata_s;
   logic [W-1:0]  rbuf_r, rbuf_s;
   logic [W-1:0]  rdata_r, rdata_s;
   logic          rsp_valid_r;
   logic          rsp_err_r;
   logic          err_s;
   logic [PW-1:0] cmd_target_s;
   logic [PW-1:0] dist_s;
   logic          addr_bad_s;
   logic [IW-1:0] bit_idx_s;

   assign cmd_target_s = PW'(cmd_addr) * PW'(W);
   assign dist_s       = cmd_target_s - phase_r;
   assign addr_bad_s   = ({1'b0, cmd_addr} >= NW_LIMIT);
   // Counter runs W..1, so W - cnt gives the bit position 0..W-1 in the word
   assign bit_idx_s    = IW'(CNT_WORD - cnt_r);

   assign cmd_ready = (state_r == ST_IDLE);
   assign busy      = (state_r != ST_IDLE);
   assign sr_shift  = (state_r == ST_SEEK) || (state_r == ST_XFER);
   assign phase     = phase_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_err   = rsp_err_r;
   assign rsp_rdata = rdata_r;

   // Serial input: recirculate unless a WRITE or CLEAR is overwriting the current bit
   always_comb begin
      sr_din = sr_dout;
      if ((state_r == ST_XFER) && (op_r == OP_WRITE)) begin
         sr_din = wdata_r[bit_idx_s];
      end else if ((state_r == ST_XFER) && (op_r == OP_CLEAR)) begin
         sr_din = 1'b0;
      end else begin
         sr_din = sr_dout;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_s  = state_r;
      target_s = target_r;
      cnt_s    = cnt_r;
      op_s     = op_r;
      wdata_s  = wdata_r;
      rbuf_s   = rbuf_r;
      rdata_s  = rdata_r;
      err_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_s     = cmd_op;
               target_s = cmd_target_s;
               wdata_s  = cmd_wdata;
               if ((cmd_op == OP_RSVD) || addr_bad_s) begin
                  err_s   = 1'b1;
                  state_s = ST_DONE;
               end else if (cmd_op == OP_CLEAR) begin
                  cnt_s   = CNT_RING;
                  state_s = ST_XFER;
               end else begin
                  cnt_s   = CNT_WORD;
                  state_s = (dist_s != PH_ZERO) ? ST_SEEK : ST_XFER;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SEEK: begin
            if ((phase_r + PH_ONE) == target_r) begin
               state_s = ST_XFER;
            end else begin
               state_s = ST_SEEK;
            end
         end
         ST_XFER: begin
            if (op_r == OP_READ) begin
               rbuf_s[bit_idx_s] = sr_dout;
            end else begin
               rbuf_s = rbuf_r;
            end
            if (cnt_r == CNT_ONE) begin
               state_s = ST_DONE;
               if (op_r == OP_READ) begin
                  rdata_s = rbuf_s;
               end else begin
                  rdata_s = rdata_r;
               end
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, phase and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         phase_r     <= PH_ZERO;
         target_r    <= PH_ZERO;
         cnt_r       <= {CW{1'b0}};
         op_r        <= OP_READ;
         wdata_r     <= {W{1'b0}};
         rbuf_r      <= {W{1'b0}};
         rdata_r     <= {W{1'b0}};
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
      end else begin
         state_r     <= state_s;
         phase_r     <= sr_shift ? (phase_r + PH_ONE) : phase_r;
         target_r    <= target_s;
         cnt_r       <= cnt_s;
         op_r        <= op_s;
         wdata_r     <= wdata_s;
         rbuf_r      <= rbuf_s;
         rdata_r     <= rdata_s;
         rsp_valid_r <= (state_s == ST_DONE);
         rsp_err_r   <= err_s;
      end
   end

endmodule

// File: tb/tb_shift_ring_ctrl.sv
// Scoreboard bench for shift_ring_ctrl with a behavioural 1024-stage ring as the external register.
module tb_shift_ring_ctrl;

   localparam int DEPTH = 1024;
   localparam int W     = 8;
   localparam int AW    = 7;
   localparam int PW    = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = 2'b00;
   logic [AW-1:0] cmd_addr = 7'd0;
   logic [W-1:0]  cmd_wdata = 8'h00;
   logic          rsp_valid;
   logic [W-1:0]  rsp_rdata;
   logic          rsp_err;
   logic          busy;
   logic [PW-1:0] phase;
   logic          sr_shift;
   logic          sr_din;
   logic          sr_dout;

   logic [DEPTH-1:0] ring = {32{32'hC3A5_96E1}};

   typedef struct {
      logic         err;
      logic [W-1:0] rdata;
      int           lat;
      int           acc;
   } exp_t;

   exp_t sbq[$];
   int   passed = 0;
   int   total = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   shift_cnt = 0;
   int   busy_cnt = 0;
   bit   cap_en = 1'b0;
   logic [7:0] cap_bits = 8'h00;

   shift_ring_ctrl #(.DEPTH(DEPTH), .W(W), .AW(AW), .PW(PW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .busy(busy), .phase(phase),
      .sr_shift(sr_shift), .sr_din(sr_din), .sr_dout(sr_dout)
   );

   initial forever #5 clk = ~clk;

   // External shift register: tail stage drives sr_dout, enabled by sr_shift
   assign sr_dout = ring[DEPTH-1];
   always @(posedge clk) if (sr_shift) ring <= {ring[DEPTH-2:0], sr_din};

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      else passed++;
   endtask

   // Activity counters sampled mid-cycle
   initial forever begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (sr_shift === 1'b1) shift_cnt++;
      if (cap_en && sr_shift === 1'b1 && phase >= 10'd40 && phase < 10'd48)
         cap_bits[phase[2:0]] = sr_din;
   end

   // Response monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
               chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
               e = sbq.pop_front();
               chk("rsp_err", rsp_err, e.err);
               chk("rsp_rdata", rsp_rdata, e.rdata);
               chk("latency", cyc - e.acc + 1, e.lat);
               done_cnt++;
            end
         end
      end
   end

   task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [W-1:0] wd,
                         input logic exp_err, input int exp_lat, input logic [W-1:0] exp_rd,
                         input int exp_shifts, input int exp_busy, input logic [PW-1:0] exp_phase);
      exp_t e;
      int n;
      int s0;
      int b0;
      int d0;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("cmd_ready_wait", cmd_ready, 1'b1);
      s0 = shift_cnt;
      b0 = busy_cnt;
      d0 = done_cnt;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_wdata = wd;
      e.err   = exp_err;
      e.rdata = exp_rd;
      e.lat   = exp_lat;
      e.acc   = cyc + 1;
      sbq.push_back(e);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      n = 0;
      while (done_cnt == d0 && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("rsp_timeout", done_cnt != d0, 1'b1);
      chk("shift_cycles", shift_cnt - s0, exp_shifts);
      chk("busy_cycles", busy_cnt - b0, exp_busy);
      chk("phase", phase, exp_phase);
   endtask

   task automatic chk_reset_state();
      chk("rst_busy", busy, 1'b0);
      chk("rst_sr_shift", sr_shift, 1'b0);
      chk("rst_phase", phase, 10'd0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_err", rsp_err, 1'b0);
      chk("rst_rsp_rdata", rsp_rdata, 8'h00);
      chk("rst_cmd_ready", cmd_ready, 1'b1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_state();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      //     op     addr    wdata  err  lat   rdata  shifts busy  phase
      do_cmd(2'b10, 7'd0,   8'h00, 1'b0, 1025, 8'h00, 1024, 1025, 10'd0);
      do_cmd(2'b00, 7'd0,   8'h00, 1'b0, 9,    8'h00, 8,    9,    10'd8);

      @(negedge clk) rst_n = 1'b0;
      #1;
      chk_reset_state();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_cmd(2'b10, 7'd0,   8'h00, 1'b0, 1025, 8'h00, 1024, 1025, 10'd0);
      cap_en = 1'b1;
      do_cmd(2'b01, 7'd5,   8'hA5, 1'b0, 49,   8'h00, 48,   49,   10'd48);
      cap_en = 1'b0;
      chk("write_sr_din_bits", cap_bits, 8'hA5);
      do_cmd(2'b00, 7'd5,   8'h00, 1'b0, 1025, 8'hA5, 1024, 1025, 10'd48);
      do_cmd(2'b11, 7'd9,   8'h00, 1'b1, 1,    8'hA5, 0,    1,    10'd48);
      do_cmd(2'b00, 7'd6,   8'h00, 1'b0, 9,    8'h00, 8,    9,    10'd56);
      do_cmd(2'b01, 7'd127, 8'h3C, 1'b0, 969,  8'h00, 968,  969,  10'd0);
      do_cmd(2'b01, 7'd0,   8'hFF, 1'b0, 9,    8'h00, 8,    9,    10'd8);
      do_cmd(2'b00, 7'd127, 8'h00, 1'b0, 1017, 8'h3C, 1016, 1017, 10'd0);
      do_cmd(2'b00, 7'd0,   8'h00, 1'b0, 9,    8'hFF, 8,    9,    10'd8);
      do_cmd(2'b00, 7'd126, 8'h00, 1'b0, 1009, 8'h00, 1008, 1009, 10'd1016);
      do_cmd(2'b00, 7'd1,   8'h00, 1'b0, 25,   8'h00, 24,   25,   10'd16);

      // WRITE addr 2 starts XFER straight away at phase 16, then reset lands mid-transfer
      d0 = done_cnt;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 2'b01;
      cmd_addr  = 7'd2;
      cmd_wdata = 8'h55;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("abort_busy_before", busy, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk_reset_state();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("abort_no_rsp", done_cnt, d0);

      do_cmd(2'b10, 7'd0,   8'h00, 1'b0, 1025, 8'h00, 1024, 1025, 10'd0);
      do_cmd(2'b01, 7'd3,   8'h81, 1'b0, 33,   8'h00, 32,   33,   10'd32);
      do_cmd(2'b00, 7'd3,   8'h00, 1'b0, 1025, 8'h81, 1024, 1025, 10'd32);

      repeat (3) @(posedge clk);
      chk("scoreboard_empty", sbq.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
